double_mult_feeder: RTL and testbench

Operand-queue and handshake front end for the `DoubleMultiply` double-precision multiplier stage. It buffers IEEE-754 double operand pairs from the trajectory math pipeline and issues them one at a time. It holds the operands stable while the multiplier runs, captures the product and exception flags into a valid/ready output register, and re-arms the multiplier's timer after every product. A watchdog drops any operation whose `data_ready` never arrives.

---
 rtl/double_mult_feeder_if.sv | 35 +++
 rtl/double_mult_feeder.sv | 119 +++++++++++
 tb/tb_double_mult_feeder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/double_mult_feeder_if.sv
// rtl/double_mult_feeder_if.sv - operand stream, multiplier bus and result stream of the double multiplier feeder
interface double_mult_feeder_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [63:0]              in_a;
    logic [63:0]              in_b;
    logic [63:0]              mult_dataa;
    logic [63:0]              mult_datab;
    logic                     mult_start;
    logic                     mult_reset;
    logic                     mult_data_ready;
    logic [63:0]              mult_result;
    logic [3:0]               mult_flags;
    logic                     out_valid;
    logic                     out_ready;
    logic [63:0]              out_result;
    logic [3:0]               out_flags;
    logic                     busy;
    logic                     timeout_err;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  in_valid, in_a, in_b, mult_data_ready, mult_result, mult_flags, out_ready,
        output in_ready, mult_dataa, mult_datab, mult_start, mult_reset,
               out_valid, out_result, out_flags, busy, timeout_err, fifo_count
    );

    modport master (
        output in_valid, in_a, in_b, mult_data_ready, mult_result, mult_flags, out_ready,
        input  in_ready, mult_dataa, mult_datab, mult_start, mult_reset,
               out_valid, out_result, out_flags, busy, timeout_err, fifo_count
    );
endinterface

// File: rtl/double_mult_feeder.sv
// rtl/double_mult_feeder.sv - operand FIFO, issue FSM, watchdog and result register for the double multiplier
module double_mult_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    double_mult_feeder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR} state_t;

    state_t          state, state_next;
    logic [63:0]     mem_a [DEPTH];
    logic [63:0]     mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic [TW-1:0]   wd_cnt;
    logic            push, pop, capture, abort, wd_clr, wd_inc;

    assign push = bus.in_valid & bus.in_ready;
    assign bus.fifo_count = count;
    // The only combinational output: the multiplier must re-arm during reset itself.
    assign bus.mult_reset = (state == S_CLEAR) | reset;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    wd_clr     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                // A ready product with a blocked slot freezes the watchdog.
                if (bus.mult_data_ready) begin
                    if (!bus.out_valid || bus.out_ready) begin
                        capture    = 1'b1;
                        state_next = S_CLEAR;
                    end
                end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    state_next = S_CLEAR;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_CLEAR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            wd_cnt          <= '0;
            bus.in_ready    <= 1'b1;
            bus.busy        <= 1'b0;
            bus.mult_start  <= 1'b0;
            bus.mult_dataa  <= '0;
            bus.mult_datab  <= '0;
            bus.timeout_err <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_result  <= '0;
            bus.out_flags   <= '0;
        end else begin
            state           <= state_next;
            count           <= count_next;
            bus.in_ready    <= (count_next != CW'(DEPTH));
            bus.busy        <= (state_next != S_IDLE) || (count_next != '0);
            bus.mult_start  <= (state_next == S_ISSUE);
            bus.timeout_err <= abort;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                bus.mult_dataa <= mem_a[rd_ptr];
                bus.mult_datab <= mem_b[rd_ptr];
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (wd_clr)      wd_cnt <= '0;
            else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
            if (capture) begin
                bus.out_valid  <= 1'b1;
                bus.out_result <= bus.mult_result;
                bus.out_flags  <= bus.mult_flags;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_double_mult_feeder.sv
// tb/tb_double_mult_feeder.sv - scoreboard bench for double_mult_feeder with a fixed-latency multiplier model
module tb_double_mult_feeder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int BFM_LAT = 5;
    localparam logic [63:0] MUTE_A = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D2     = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D3     = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D6     = 64'h4018_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    double_mult_feeder_if #(.DEPTH(DEPTH)) bus ();

    double_mult_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
    } exp_t;
    exp_t sb[$];

    // Multiplier stand-in: 2.0*3.0 is exact, all-ones exponent is NaN, otherwise a ^ b.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        if (a == D2 && b == D3) return {4'b0000, D6};
        if (a[62:52] == 11'h7FF) return {4'b1000, a};
        r = a ^ b;
        return {3'b000, (r == 64'd0), r};
    endfunction

    function automatic bit model_responds(input logic [63:0] a);
        return a != MUTE_A;
    endfunction

    // Multiplier BFM
    initial begin
        int lat;
        lat = 0;
        bus.mult_data_ready = 1'b0;
        bus.mult_result     = '0;
        bus.mult_flags      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mult_reset) begin
                bus.mult_data_ready = 1'b0;
                lat = 0;
            end else if (bus.mult_start) begin
                lat = BFM_LAT;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0 && model_responds(bus.mult_dataa)) begin
                    {bus.mult_flags, bus.mult_result} = model(bus.mult_dataa, bus.mult_datab);
                    bus.mult_data_ready = 1'b1;
                end
            end
        end
    end

    // Monitor
    int cyc = 0, start_cyc = 0, rise_cyc = 0, tmo_gap = 0;
    int n_start = 0, n_mreset = 0, n_tmo = 0, n_out = 0;
    logic prev_ov = 1'b0, prev_or = 1'b0;
    logic [63:0] prev_res = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.mult_start) begin
                    start_cyc = cyc;
                    n_start++;
                    check("start_vs_mult_reset", bus.mult_reset, 0);
                end
                if (bus.mult_reset) n_mreset++;
                if (bus.timeout_err) begin
                    n_tmo++;
                    tmo_gap = cyc - start_cyc;
                    check("tmo_with_mult_reset", bus.mult_reset, 1);
                end
                if (bus.out_valid && !prev_ov) rise_cyc = cyc;
                if (bus.out_valid && prev_ov && !prev_or)
                    check("hold_result", bus.out_result, prev_res);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_result", bus.out_result, e.res);
                        check("out_flags", 64'(bus.out_flags), 64'(e.flg));
                        n_out++;
                    end
                end
                prev_ov  = bus.out_valid;
                prev_or  = bus.out_ready;
                prev_res = bus.out_result;
            end
        end
    end

    task automatic push(input logic [63:0] a, input logic [63:0] b);
        bit ready;
        exp_t e;
        ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        for (int k = 0; k < 200; k++) begin
            ready = bus.in_ready;
            @(posedge clk);
            #1;
            if (ready) break;
        end
        if (!ready) begin
            check("push_timeout", 0, 1);
        end else if (model_responds(a)) begin
            {e.flg, e.res} = model(a, b);
            sb.push_back(e);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.busy && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_bound", 64'(done), 1);
    endtask

    function automatic logic [63:0] rnd_operand();
        return {$urandom, $urandom} & 64'hBFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        int n0, t0, o0, s0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",    64'(bus.in_ready), 1);
        check("rst_mult_reset",  64'(bus.mult_reset), 1);
        check("rst_out_valid",   64'(bus.out_valid), 0);
        check("rst_busy",        64'(bus.busy), 0);
        check("rst_fifo_count",  64'(bus.fifo_count), 0);
        check("rst_mult_start",  64'(bus.mult_start), 0);
        check("rst_mult_dataa",  bus.mult_dataa, 0);
        check("rst_out_result",  bus.out_result, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_mult_reset", 64'(bus.mult_reset), 0);

        // single op
        bus.out_ready = 1'b1;
        n0 = n_mreset;
        o0 = n_out;
        push(D2, D3);
        wait_idle();
        check("single_latency", 64'(rise_cyc - start_cyc), 64'(BFM_LAT + 1));
        check("single_mreset_pulses", 64'(n_mreset - n0), 1);
        check("single_outputs", 64'(n_out - o0), 1);
        check("single_busy_low", 64'(bus.busy), 0);

        // NaN flags
        push(64'h7FF8_0000_0000_0123, D2);
        wait_idle();

        // full FIFO with blocked output, then back-to-back drain
        bus.out_ready = 1'b0;
        t0 = n_tmo;
        o0 = n_out;
        for (int i = 0; i < 5; i++) push(rnd_operand(), rnd_operand());
        check("full_in_ready", 64'(bus.in_ready), 0);
        check("full_count", 64'(bus.fifo_count), 4);
        repeat (3 * TIMEOUT) @(posedge clk);
        #1;
        check("stall_out_valid", 64'(bus.out_valid), 1);
        check("stall_data_ready", 64'(bus.mult_data_ready), 1);
        check("stall_count", 64'(bus.fifo_count), 3);
        check("stall_no_timeout", 64'(n_tmo - t0), 0);
        check("stall_head_result", bus.out_result, sb[0].res);
        bus.out_ready = 1'b1;
        wait_idle();
        check("full_all_out", 64'(n_out - o0), 5);

        // watchdog abort then next pair issues
        t0 = n_tmo;
        o0 = n_out;
        push(MUTE_A, D3);
        push(rnd_operand(), rnd_operand());
        wait_idle();
        check("tmo_pulses", 64'(n_tmo - t0), 1);
        check("tmo_gap", 64'(tmo_gap), 64'(TIMEOUT + 1));
        check("tmo_next_out", 64'(n_out - o0), 1);

        // asynchronous reset while waiting with two queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd_operand(), rnd_operand());
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_count", 64'(bus.fifo_count), 2);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        check("arst_fifo_count", 64'(bus.fifo_count), 0);
        check("arst_busy",       64'(bus.busy), 0);
        check("arst_mult_reset", 64'(bus.mult_reset), 1);
        check("arst_in_ready",   64'(bus.in_ready), 1);
        check("arst_mult_datab", bus.mult_datab, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        s0 = n_start;
        o0 = n_out;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_arst_no_start", 64'(n_start - s0), 0);
        check("post_arst_out_valid", 64'(bus.out_valid), 0);
        check("post_arst_no_out", 64'(n_out - o0), 0);

        push(D2, D3);
        wait_idle();
        check("recover_out", 64'(n_out - o0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck expected completion");
        $fatal(1);
    end
endmodule
